// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the program counter, requests instruction
// words from instruction memory and presents one latched instruction per
// EXEC cycle to the decoder.
//
// Optional feature: define FETCH_COUNT_EN to add the FETCH_COUNT output,
// a free-running count of retired instructions (EXEC->FETCH transitions).
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | PC presented to IMEM, read requested; capture if IMEM ready
// WAIT  | IMEM busy, PC held, read still requested until word arrives
// EXEC  | INSTRUCTION valid; PC advances once data memory is not busy
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] NEXT_PC,
    input  logic        DMEM_BUSYWAIT,
    input  logic        IMEM_BUSYWAIT,
    input  logic [31:0] IMEM_READDATA,
    output logic [31:0] PC,
    output logic [29:0] IMEM_ADDRESS,
    output logic        IMEM_READ,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID,
`ifdef FETCH_COUNT_EN
    output logic [31:0] FETCH_COUNT,
`endif
    output logic        STALL
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    // Word-aligned reset vector; the low bits of the parameter are ignored.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic        r_instr_valid;
    logic        w_capture;
    logic        w_retire;

    // State register; reset always lands in FETCH so the first edge after
    // release starts a fetch at the reset vector.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus the capture (IMEM word accepted) and retire
    // (instruction consumed, PC advances) strobes.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (!IMEM_BUSYWAIT) begin
                    w_capture    = 1'b1;
                    w_state_next = S_EXEC;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!IMEM_BUSYWAIT) begin
                    w_capture    = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!DMEM_BUSYWAIT) begin
                    w_retire     = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // Program counter; only moves when an instruction retires, so it is
    // stable across the whole FETCH/WAIT interval. Low two bits forced to 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pc <= RESET_PC_ALIGNED;
        end else if (w_retire) begin
            r_pc <= {NEXT_PC[31:2], 2'b00};
        end
    end

    // Instruction latch; holds its word through data-memory stalls.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_instruction <= 32'h0000_0000;
        end else if (w_capture) begin
            r_instruction <= IMEM_READDATA;
        end
    end

    // Valid flag: set on capture, cleared on retire.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_instr_valid <= 1'b0;
        end else if (w_capture) begin
            r_instr_valid <= 1'b1;
        end else if (w_retire) begin
            r_instr_valid <= 1'b0;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_retire) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign FETCH_COUNT = r_fetch_count;
`endif

    // The read request is gated by reset so that asserting reset mid-fetch
    // drops the request immediately, even though the state is already FETCH.
    assign PC           = r_pc;
    assign IMEM_ADDRESS = r_pc[31:2];
    assign IMEM_READ    = RESET & (r_state != S_EXEC);
    assign INSTRUCTION  = r_instruction;
    assign INSTR_VALID  = r_instr_valid;
    assign STALL        = (r_state != S_EXEC) | DMEM_BUSYWAIT;

endmodule
